// File: rtl/expr_pipe_eval.sv
// rtl/expr_pipe_eval.sv - two-stage multi-lane expression evaluator with valid/ready handshake
module expr_pipe_eval #(
  parameter int W     = 6,
  parameter int LANES = 3,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [LANES-1:0]     sgn,
  input  logic [LANES*W-1:0]   a,
  input  logic [LANES*W-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   y,
  output logic [LANES-1:0]     ovf,
  output logic [CW-1:0]        cnt
);

  localparam int SB = $clog2(W);
  // W always fits in SB+1 bits because W <= 2**SB
  localparam logic [SB:0] W_L = (SB+1)'(W);

  logic                 s1_valid_q, s1_valid_d;
  logic [2:0]           op_q, op_d;
  logic [LANES-1:0]     sgn_q, sgn_d;
  logic [LANES*W-1:0]   a_q, a_d;
  logic [LANES*W-1:0]   b_q, b_d;
  logic                 out_valid_q, out_valid_d;
  logic [LANES*W-1:0]   y_q, y_d;
  logic [LANES-1:0]     ovf_q, ovf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LANES*W-1:0]   acc_q, acc_d;

  logic                 s2_adv;
  logic                 s1_move;
  logic                 in_xfer;
  logic [LANES*W-1:0]   res_y;
  logic [LANES-1:0]     res_ovf;
  logic [LANES*W-1:0]   acc_new;

  // Per-lane ALU working on the stage-1 contents; lanes never share carries or flags
  always_comb begin
    logic [W-1:0]   la, lb, ly, lacc;
    logic [W:0]     sum, dif;
    logic [SB-1:0]  sh;
    logic [2*W-1:0] shl_ext;
    logic           lo, ls;
    res_y   = '0;
    res_ovf = '0;
    acc_new = '0;
    la = '0; lb = '0; ly = '0; lacc = '0;
    sum = '0; dif = '0; sh = '0; shl_ext = '0; lo = 1'b0; ls = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      la      = a_q[i*W +: W];
      lb      = b_q[i*W +: W];
      ls      = sgn_q[i];
      sh      = lb[SB-1:0];
      sum     = {1'b0, la} + {1'b0, lb};
      dif     = {1'b0, la} - {1'b0, lb};
      // upper half collects the bits pushed out of the lane by a left shift
      shl_ext = {{W{1'b0}}, la} << sh;
      lacc    = acc_q[i*W +: W] ^ la;
      ly      = '0;
      lo      = 1'b0;
      case (op_q)
        3'd0: begin
          ly = sum[W-1:0];
          lo = ls ? ((la[W-1] == lb[W-1]) && (sum[W-1] != la[W-1])) : sum[W];
        end
        3'd1: begin
          ly = dif[W-1:0];
          lo = ls ? ((la[W-1] != lb[W-1]) && (dif[W-1] != la[W-1])) : dif[W];
        end
        3'd2: ly = la & lb;
        3'd3: ly = la ^ lb;
        3'd4: begin
          if (ls) ly = {{(W-1){1'b0}}, ($signed(la) < $signed(lb))};
          else    ly = {{(W-1){1'b0}}, (la < lb)};
        end
        3'd5: begin
          ly = shl_ext[W-1:0];
          lo = ({1'b0, sh} >= W_L) ? (|la) : (|shl_ext[2*W-1:W]);
        end
        3'd6: begin
          // >>> already saturates to sign bits for shift amounts >= W
          if (ls) ly = $signed(la) >>> sh;
          else    ly = la >> sh;
        end
        default: ly = lacc;
      endcase
      res_y[i*W +: W]   = ly;
      res_ovf[i]        = lo;
      acc_new[i*W +: W] = lacc;
    end
  end

  // Handshake and next-state for both pipeline stages, the counter and the accumulators
  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_adv;
    in_xfer  = in_valid && in_ready;
    s1_move  = s1_valid_q && s2_adv;

    s1_valid_d = s1_valid_q;
    op_d       = op_q;
    sgn_d      = sgn_q;
    a_d        = a_q;
    b_d        = b_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_xfer) begin
      op_d  = op;
      sgn_d = sgn;
      a_d   = a;
      b_d   = b;
    end

    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    y_d         = s1_move ? res_y : y_q;
    ovf_d       = s1_move ? res_ovf : ovf_q;
    acc_d       = (s1_move && (op_q == 3'd7)) ? acc_new : acc_q;
    cnt_d       = in_xfer ? cnt_q + CW'(1) : cnt_q;
  end

  // State registers; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      op_q        <= '0;
      sgn_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      op_q        <= op_d;
      sgn_q       <= sgn_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_expr_pipe_eval.sv
// tb/tb_expr_pipe_eval.sv - self-checking bench for expr_pipe_eval
`timescale 1ns/1ps
module tb_expr_pipe_eval;

  localparam int W = 6, L = 3, CW = 16;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    op, sgn, ovf;
  logic [17:0]   a, b, y;
  logic [15:0]   cnt;

  always #5 clk = ~clk;

  expr_pipe_eval #(.W(W), .LANES(L), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sgn(sgn), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .cnt(cnt)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  sgn;
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] y;
    logic [2:0]  ovf;
  } vec_t;

  typedef struct {
    logic [17:0] y;
    logic [2:0]  ovf;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  logic [15:0] exp_cnt = '0;
  logic [5:0]  macc[3];
  bit          sb_en = 1'b1;
  bit          saw_bp = 1'b0;
  bit          prev_stall = 1'b0;
  logic [17:0] prev_y;
  logic [2:0]  prev_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic logic [17:0] pk(input int l2, input int l1, input int l0);
    return {6'(l2), 6'(l1), 6'(l0)};
  endfunction

  // Reference model: plain integer arithmetic per lane
  function automatic void model(input logic [2:0] o, input logic [2:0] s,
                                input logic [17:0] va, input logic [17:0] vb,
                                output logic [17:0] ey, output logic [2:0] eo);
    int ua, ub, sa, sbv, r, sh;
    ey = '0;
    eo = '0;
    for (int l = 0; l < 3; l++) begin
      ua  = int'(va[l*6 +: 6]);
      ub  = int'(vb[l*6 +: 6]);
      sa  = (ua >= 32) ? ua - 64 : ua;
      sbv = (ub >= 32) ? ub - 64 : ub;
      sh  = ub % 8;
      r   = 0;
      case (o)
        3'd0: begin
          r = ua + ub;
          if (s[l]) eo[l] = ((sa + sbv) > 31) || ((sa + sbv) < -32);
          else      eo[l] = r > 63;
        end
        3'd1: begin
          r = ua - ub;
          if (s[l]) eo[l] = ((sa - sbv) > 31) || ((sa - sbv) < -32);
          else      eo[l] = ua < ub;
        end
        3'd2: r = ua & ub;
        3'd3: r = ua ^ ub;
        3'd4: r = s[l] ? int'(sa < sbv) : int'(ua < ub);
        3'd5: begin
          if (sh >= 6) begin
            r = 0;
            eo[l] = ua != 0;
          end else begin
            r = ua << sh;
            eo[l] = (ua >> (6 - sh)) != 0;
          end
        end
        3'd6: begin
          if (s[l]) r = (sh >= 6) ? ((sa < 0) ? -1 : 0) : (sa >>> sh);
          else      r = ua >> sh;
        end
        default: begin
          macc[l] = macc[l] ^ 6'(ua);
          r = int'(macc[l]);
        end
      endcase
      ey[l*6 +: 6] = 6'(r);
    end
  endfunction

  // Output monitor: pops the scoreboard on every output transfer and checks stall stability
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      prev_stall = 1'b0;
      for (int i = 0; i < 3; i++) macc[i] = '0;
      exp_cnt = '0;
    end else if (sb_en) begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_y", 32'(y), 32'(prev_y));
        check("hold_ovf", 32'(ovf), 32'(prev_ovf));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("y", 32'(y), 32'(mon_e.y));
          check("ovf", 32'(ovf), 32'(mon_e.ovf));
          pops++;
        end
      end
      if (in_valid && !in_ready) saw_bp = 1'b1;
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
      prev_ovf   = ovf;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the edge that took the transfer
  task automatic send(input logic [2:0] o, input logic [2:0] s, input logic [17:0] va,
                      input logic [17:0] vb, input logic [17:0] ey, input logic [2:0] eo);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    op = o; sgn = s; a = va; b = vb; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.y = ey;
        e.ovf = eo;
        sbq.push_back(e);
        exp_cnt++;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [2:0] o, input logic [2:0] s,
                            input logic [17:0] va, input logic [17:0] vb);
    logic [17:0] ey;
    logic [2:0]  eo;
    model(o, s, va, vb, ey, eo);
    send(o, s, va, vb, ey, eo);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && (sbq.size() != 0 || out_valid); k++) @(posedge clk);
    #1;
    check("drain", 32'(sbq.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   n, base, seen;
    bit   done;
    tbl[0] = '{3'd0, 3'b010, pk(5, 31, 63), pk(6, 1, 1),   pk(11, 32, 0),  3'b011};
    tbl[1] = '{3'd6, 3'b001, pk(63, 32, 32), pk(0, 2, 7),  pk(63, 8, 63),  3'b000};
    tbl[2] = '{3'd1, 3'b000, pk(0, 10, 3),  pk(0, 4, 5),   pk(0, 6, 62),   3'b001};
    tbl[3] = '{3'd1, 3'b111, pk(5, 31, 32), pk(7, 63, 1),  pk(62, 32, 31), 3'b011};
    tbl[4] = '{3'd2, 3'b111, pk(63, 42, 15), pk(21, 51, 60), pk(21, 34, 12), 3'b000};
    tbl[5] = '{3'd3, 3'b000, pk(63, 42, 15), pk(21, 51, 60), pk(42, 25, 51), 3'b000};
    tbl[6] = '{3'd4, 3'b010, pk(40, 2, 2),  pk(2, 40, 40), pk(0, 0, 1),    3'b000};
    tbl[7] = '{3'd5, 3'b000, pk(1, 12, 3),  pk(6, 3, 4),   pk(0, 32, 48),  3'b110};
    tbl[8] = '{3'd6, 3'b010, pk(48, 48, 48), pk(6, 2, 4),  pk(0, 60, 3),   3'b000};
    tbl[9] = '{3'd0, 3'b111, pk(16, 63, 32), pk(15, 63, 32), pk(31, 62, 0), 3'b001};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; sgn = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;

    // latency: result visible exactly two cycles after the transfer cycle
    send(3'd3, 3'b000, pk(1, 2, 3), pk(1, 1, 1), pk(0, 3, 2), 3'b000);
    @(negedge clk);
    check("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_on_time", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    drain();

    // table vectors, back to back
    base = pops;
    for (int i = 0; i < 10; i++)
      send(tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].ovf);
    drain();
    check("tbl_pops", 32'(pops - base), 32'd10);
    check("tbl_cnt", 32'(cnt), 32'(exp_cnt));

    // LT stream with a 3-cycle output stall
    @(posedge clk); #1;
    do_reset();
    saw_bp = 1'b0;
    base = pops;
    fork
      begin
        for (int k = 0; k < 5; k++)
          send_model(3'd4, 3'($urandom), 18'($urandom), 18'($urandom));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("lt_backpressure", 32'(saw_bp), 32'd1);
    check("lt_pops", 32'(pops - base), 32'd5);
    check("lt_cnt", 32'(cnt), 32'd5);

    // accumulator sequence, then reset clears it
    @(posedge clk); #1;
    do_reset();
    send(3'd7, 3'b000, pk(0, 7, 5), '0, pk(0, 7, 5), 3'b000);
    send(3'd7, 3'b000, pk(0, 7, 3), '0, pk(0, 0, 6), 3'b000);
    send(3'd7, 3'b000, pk(0, 7, 5), '0, pk(0, 7, 3), 3'b000);
    drain();
    @(posedge clk); #1;
    do_reset();
    send(3'd7, 3'b000, pk(0, 0, 1), '0, pk(0, 0, 1), 3'b000);
    drain();

    // reset with both stages full
    @(posedge clk); #1;
    do_reset();
    out_ready = 1'b0;
    send_model(3'd0, 3'b000, pk(1, 2, 3), pk(1, 1, 1));
    send_model(3'd1, 3'b000, pk(4, 5, 6), pk(1, 1, 1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(cnt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_stale", 32'(seen), 32'd0);

    // random traffic with random output stalls
    @(posedge clk); #1;
    do_reset();
    base = pops;
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++)
          send_model(3'($urandom), 3'($urandom), 18'($urandom), 18'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("rnd_pops", 32'(pops - base), 32'd40);
    check("rnd_cnt", 32'(cnt), 32'(exp_cnt));

    // counter wrap: 2^CW + 2 transfers
    @(posedge clk); #1;
    do_reset();
    sb_en = 1'b0;
    op = 3'd2; in_valid = 1'b1; n = 0;
    for (int k = 0; k < 70000 && n < 65538; k++) begin
      @(negedge clk);
      if (in_valid && in_ready) n++;
      @(posedge clk); #1;
      if (n == 65538) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("wrap_xfers", 32'(n), 32'd65538);
    @(negedge clk);
    check("wrap_cnt", 32'(cnt), 32'd2);
    @(posedge clk); #1;
    do_reset();
    sb_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
